i2s_clk_ctrl: RTL and testbench

I2S_CLK_CTRL -- requirements
Module: i2s_clk_ctrl

---
 rtl/i2s_ctrl_pkg.sv | 5 +
 rtl/i2s_sck_div.sv | 38 +++
 rtl/i2s_clk_ctrl.sv | 73 +++++++
 tb/tb_i2s_clk_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_ctrl_pkg.sv
// i2s_ctrl_pkg: shared FSM state type and bit-counter width for the I2S clock controller
package i2s_ctrl_pkg;
  localparam int BIT_CNT_W = 5;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
endpackage

// File: rtl/i2s_sck_div.sv
// i2s_sck_div: SCK divider; toggles sck every div_i+1 enabled cycles and emits registered edge strobes
module i2s_sck_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             sck_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             fall_evt_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic sck_q, sck_d, rise_q, fall_q, wrap;
  always_comb begin
    wrap       = en_i && (cnt_q == div_i);
    cnt_d      = (!en_i || wrap) ? '0 : cnt_q + 1'b1;
    sck_d      = en_i && (sck_q ^ wrap);
    fall_evt_o = wrap && sck_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      sck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sck_q  <= sck_d;
      rise_q <= wrap && !sck_q;
      fall_q <= fall_evt_o;
    end
  end
  assign sck_o  = sck_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/i2s_clk_ctrl.sv
// i2s_clk_ctrl: I2S master SCK/WS generator with shadowed config and frame-aligned graceful stop
module i2s_clk_ctrl
  import i2s_ctrl_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cfg_en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [4:0]       cfg_data_size_i,
  output logic             sck_o,
  output logic             ws_o,
  output logic             sck_rise_o,
  output logic             sck_fall_o,
  output logic             frame_end_o,
  output logic             busy_o
);
  state_e state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [BIT_CNT_W-1:0] size_q, bit_q, bit_d;
  logic ws_q, ws_d, fe_q, fe_d, busy_q, run_en, fall_evt, last_bit;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end
  // STOP only leaves for IDLE right after a frame end, so no partial frame is emitted
  always_comb begin
    state_d = (state_q == IDLE) ? (cfg_en_i ? RUN : IDLE) :
              cfg_en_i          ? RUN :
              (state_q == STOP && fe_q) ? IDLE : STOP;
  end
  // Divider runs only while staying active, so the IDLE-entry cycle clears sck without a runt pulse
  always_comb begin
    run_en   = (state_q != IDLE) && (state_d != IDLE);
    last_bit = (bit_q == size_q);
    bit_d    = !run_en ? '0 : !fall_evt ? bit_q : last_bit ? '0 : bit_q + 1'b1;
    ws_d     = run_en && (ws_q ^ (fall_evt && last_bit));
    fe_d     = run_en && fall_evt && last_bit && ws_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_q  <= '0;
      size_q <= '0;
      bit_q  <= '0;
      ws_q   <= 1'b0;
      fe_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (state_q == IDLE && cfg_en_i) begin
        div_q  <= cfg_div_i;
        size_q <= cfg_data_size_i;
      end
      bit_q  <= bit_d;
      ws_q   <= ws_d;
      fe_q   <= fe_d;
      busy_q <= (state_d != IDLE);
    end
  end
  i2s_sck_div #(.DIV_W(DIV_W)) u_sck_div (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (run_en),
    .div_i      (div_q),
    .sck_o      (sck_o),
    .rise_o     (sck_rise_o),
    .fall_o     (sck_fall_o),
    .fall_evt_o (fall_evt)
  );
  assign ws_o        = ws_q;
  assign frame_end_o = fe_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// tb_i2s_clk_ctrl: scenario tasks checked against a closed-form waveform model of the I2S clock controller
module tb_i2s_clk_ctrl;
  localparam int DIV_W = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cfg_en = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [4:0] cfg_size = '0;
  logic sck, ws, rise, fall, fe, busy;
  logic [5:0] obs;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  i2s_clk_ctrl #(.DIV_W(DIV_W)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_en_i        (cfg_en),
    .cfg_div_i       (cfg_div),
    .cfg_data_size_i (cfg_size),
    .sck_o           (sck),
    .ws_o            (ws),
    .sck_rise_o      (rise),
    .sck_fall_o      (fall),
    .frame_end_o     (fe),
    .busy_o          (busy)
  );
  assign obs = {sck, ws, rise, fall, fe, busy};
  // Waveform k cycles after entering RUN: sck toggles every d+1 cycles, ws every z+1 falls
  function automatic logic [5:0] wave(int k, int d, int z);
    int n, f;
    logic on, r, fl;
    n  = k / (d + 1);
    on = (k % (d + 1)) == 0;
    f  = n / 2;
    r  = on && (n % 2 == 1);
    fl = on && n >= 2 && (n % 2 == 0);
    return {1'(n % 2), 1'((f / (z + 1)) % 2), r, fl, fl && (f % (2 * (z + 1)) == 0), 1'b1};
  endfunction
  logic [5:0] exp_v;
  logic m_act, m_stop, n_act;
  int cyc = 0;
  int m_start, m_div, m_size, n_st, n_d, n_z;
  always_comb begin
    n_act = m_act ? !(m_stop && !cfg_en && exp_v[1]) : cfg_en;
    n_st  = m_act ? m_start : cyc + 1;
    n_d   = m_act ? m_div : int'(cfg_div);
    n_z   = m_act ? m_size : int'(cfg_size);
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_act   <= 1'b0;
      m_stop  <= 1'b0;
      m_start <= 0;
      m_div   <= 0;
      m_size  <= 0;
      exp_v   <= '0;
    end else begin
      m_act   <= n_act;
      m_stop  <= n_act && !cfg_en;
      m_start <= n_st;
      m_div   <= n_d;
      m_size  <= n_z;
      exp_v   <= n_act ? wave(cyc + 1 - n_st, n_d, n_z) : '0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    cfg_en = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask
  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (obs !== 6'b0) begin n_fail++; $display("FAIL reset_idle c=%0d got=%b exp=000000", c, obs); end
      tick();
    end
  endtask
  task automatic test_start();
    int got[5];
    int want[5];
    for (int i = 0; i < 5; i++) got[i] = -1;
    want = '{1, 3, 5, 17, 33};
    do_reset();
    cfg_div = 1;
    cfg_size = 3;
    cfg_en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL start_model c=%0d got=%b exp=%b", c, obs, exp_v); end
      if (busy && got[0] < 0) got[0] = c;
      if (rise && got[1] < 0) got[1] = c;
      if (fall && got[2] < 0) got[2] = c;
      if (ws && got[3] < 0) got[3] = c;
      if (fe && got[4] < 0) got[4] = c;
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (got[i] != want[i]) begin n_fail++; $display("FAIL start_timing idx=%0d got=%0d exp=%0d", i, got[i], want[i]); end
    end
  endtask
  task automatic test_graceful_stop();
    int rises = 0;
    int c = 0;
    logic prev_fe = 1'b0;
    logic done = 1'b0;
    do_reset();
    cfg_div = 0;
    cfg_size = 7;
    cfg_en = 1'b1;
    while (!done && c < 400) begin
      prev_fe = fe;
      tick();
      c++;
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL stop_model c=%0d got=%b exp=%b", c, obs, exp_v); end
      if (ws && rise) rises++;
      if (ws && rises == 3) cfg_en = 1'b0;
      done = !busy;
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL stop_timeout busy=%b exp=0", busy); end
    n_tests++;
    if ({prev_fe, sck, ws} !== 3'b100) begin n_fail++; $display("FAIL stop_idle got fe_prev,sck,ws=%b exp=100", {prev_fe, sck, ws}); end
    n_tests++;
    if (rises != 8) begin n_fail++; $display("FAIL stop_right_periods got=%0d exp=8", rises); end
  endtask
  task automatic test_stop_cancel();
    int d, per, gap;
    int last = -1;
    int nfe = 0;
    int c = 0;
    d = $urandom_range(0, 2);
    gap = $urandom_range(1, 10);
    per = 32 * (d + 1);
    do_reset();
    cfg_div = 16'(d);
    cfg_size = 7;
    cfg_en = 1'b1;
    while (nfe < 4 && c < 2000) begin
      tick();
      c++;
      n_tests++;
      if (obs !== exp_v || (c > 1 && !busy)) begin n_fail++; $display("FAIL cancel_model c=%0d got=%b exp=%b", c, obs, exp_v); end
      if (fe) begin
        if (last >= 0) begin
          n_tests++;
          if (c - last != per) begin n_fail++; $display("FAIL cancel_spacing got=%0d exp=%0d", c - last, per); end
        end
        last = c;
        nfe++;
      end
      if (nfe == 1 && c == last + 5) cfg_en = 1'b0;
      if (nfe == 1 && c == last + 5 + gap) cfg_en = 1'b1;
    end
    n_tests++;
    if (nfe != 4) begin n_fail++; $display("FAIL cancel_timeout frames=%0d exp=4", nfe); end
  endtask
  task automatic test_cfg_isolation();
    int lr = -1;
    int c = 0;
    do_reset();
    cfg_div = 3;
    cfg_size = 3;
    cfg_en = 1'b1;
    for (c = 1; c <= 80; c++) begin
      tick();
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL iso_model c=%0d got=%b exp=%b", c, obs, exp_v); end
      if (c == 10) cfg_div = 9;
      if (rise) begin
        if (lr >= 0) begin
          n_tests++;
          if (c - lr != 8) begin n_fail++; $display("FAIL iso_period_old got=%0d exp=8", c - lr); end
        end
        lr = c;
      end
    end
    cfg_en = 1'b0;
    c = 0;
    while (busy && c < 500) begin
      tick();
      c++;
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL iso_stop_model c=%0d got=%b exp=%b", c, obs, exp_v); end
    end
    n_tests++;
    if (busy) begin n_fail++; $display("FAIL iso_stop_timeout busy=%b exp=0", busy); end
    cfg_en = 1'b1;
    lr = -1;
    for (c = 1; c <= 100; c++) begin
      tick();
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL iso_new_model c=%0d got=%b exp=%b", c, obs, exp_v); end
      if (rise) begin
        if (lr >= 0) begin
          n_tests++;
          if (c - lr != 20) begin n_fail++; $display("FAIL iso_period_new got=%0d exp=20", c - lr); end
        end
        lr = c;
      end
    end
  endtask
  task automatic test_size0();
    logic pw = 1'b0;
    do_reset();
    cfg_div = 16'($urandom_range(0, 3));
    cfg_size = 0;
    cfg_en = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL size0_model c=%0d got=%b exp=%b", c, obs, exp_v); end
      if (fall) begin
        n_tests++;
        if (ws === pw) begin n_fail++; $display("FAIL size0_ws_toggle c=%0d got=%b exp=%b", c, ws, ~pw); end
      end
      pw = ws;
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    cfg_div = 1;
    cfg_size = 3;
    cfg_en = 1'b1;
    repeat (22) begin
      tick();
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rstmid_model got=%b exp=%b", obs, exp_v); end
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_tests++;
    if (obs !== 6'b0) begin n_fail++; $display("FAIL rstmid_async got=%b exp=000000", obs); end
    cfg_en = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_tests++;
      if (obs !== 6'b0) begin n_fail++; $display("FAIL rstmid_quiet c=%0d got=%b exp=000000", c, obs); end
    end
    cfg_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rstmid_restart c=%0d got=%b exp=%b", c, obs, exp_v); end
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      cfg_div = 16'($urandom_range(0, 3));
      cfg_size = 5'($urandom_range(0, 15));
      cfg_en = 1'b1;
      for (int c = 0; c < 500; c++) begin
        tick();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL random_model it=%0d c=%0d got=%b exp=%b", it, c, obs, exp_v); end
        if ($urandom_range(0, 49) == 0) cfg_en = ~cfg_en;
        cfg_div = 16'($urandom_range(0, 3));
        cfg_size = 5'($urandom_range(0, 15));
      end
    end
  endtask
  initial begin
    test_reset();
    test_start();
    test_graceful_stop();
    test_stop_cancel();
    test_cfg_isolation();
    test_size0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
